uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter (8-bit data, write-strobe, THRE flag) between NREQ byte-stream requesters, such as CPU firmware path, log engine and DMA.
- Arbitration is round-robin with packet locking: a granted requester keeps the UART until it marks a byte as last, or goes idle for TIMEOUT cycles.
- Sits between the requesters and the UART core's TX write port; the UART's baud/RX side is untouched.

---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX write port among NREQ byte streams,
// with packet locking until a last byte or an idle timeout; all outputs registered.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16,
   parameter int CNTW    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      last,
   input  logic [8*NREQ-1:0]    data,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      grant,
   output logic [7:0]           uart_d,
   output logic                 uart_wrtx,
   input  logic                 uart_thre,
   output logic                 busy,
   output logic [CNTW-1:0]      tx_count
);
   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;

   state_t            state, state_n;
   logic [PW-1:0]     ptr, ptr_n, owner, owner_n;
   logic [TW-1:0]     timer, timer_n;
   logic              last_q, last_n;
   logic [NREQ-1:0]   grant_n, ack_n;
   logic              wrtx_n;
   logic [7:0]        d_n;
   logic [CNTW-1:0]   cnt_n;
   logic              found;
   logic [PW-1:0]     winner, cand;

   // Search starts just after the previous owner so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      cand   = ptr;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      timer_n = timer;
      last_n  = last_q;
      grant_n = grant;
      ack_n   = '0;
      wrtx_n  = 1'b0;
      d_n     = uart_d;
      cnt_n   = tx_count;
      case (state)
         IDLE: begin
            if (found) begin
               grant_n = NREQ'(1) << winner;
               owner_n = winner;
               timer_n = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (req[owner]) begin
               // Stalling on THRE leaves the idle timer untouched.
               if (uart_thre) begin
                  d_n     = data[{owner, 3'b000} +: 8];
                  wrtx_n  = 1'b1;
                  ack_n   = grant;
                  last_n  = last[owner];
                  cnt_n   = tx_count + CNTW'(1);
                  state_n = SEND;
               end
            end else if (timer == TW'(TIMEOUT - 1)) begin
               grant_n = '0;
               ptr_n   = owner;
               state_n = IDLE;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         SEND: begin
            if (last_q) begin
               grant_n = '0;
               ptr_n   = owner;
               state_n = IDLE;
            end else begin
               state_n = GAP;
            end
         end
         GAP: begin
            timer_n = '0;
            state_n = GRANT;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= PW'(NREQ - 1);
         owner     <= '0;
         timer     <= '0;
         last_q    <= 1'b0;
         grant     <= '0;
         ack       <= '0;
         uart_wrtx <= 1'b0;
         uart_d    <= '0;
         busy      <= 1'b0;
         tx_count  <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         owner     <= owner_n;
         timer     <= timer_n;
         last_q    <= last_n;
         grant     <= grant_n;
         ack       <= ack_n;
         uart_wrtx <= wrtx_n;
         uart_d    <= d_n;
         busy      <= |grant_n;
         tx_count  <= cnt_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues bytes per requester and expected UART writes;
// a negedge monitor pops expectations on every uart_wrtx and checks invariants.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int CNTW = 4;

   logic              clk, reset;
   logic [NREQ-1:0]   req, last, ack, grant;
   logic [8*NREQ-1:0] data;
   logic [7:0]        uart_d;
   logic              uart_wrtx, uart_thre, busy;
   logic [CNTW-1:0]   tx_count;

   uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .req(req), .last(last), .data(data),
      .ack(ack), .grant(grant), .uart_d(uart_d), .uart_wrtx(uart_wrtx),
      .uart_thre(uart_thre), .busy(busy), .tx_count(tx_count)
   );

   typedef struct packed {
      logic [1:0]      idx;
      logic [7:0]      d;
      logic [CNTW-1:0] cnt;
   } exp_t;

   exp_t         exp_q[$];
   logic [8:0]   rq[NREQ][$];
   int           wr_cyc[$];
   int           compared = 0, mismatched = 0, cyc = 0;
   logic         mon_en = 1'b0;
   logic [CNTW-1:0] exp_cnt = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      compared++;
      if (act !== req_v) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
      end
   endtask

   task automatic put(input int i, input logic [7:0] d, input logic l);
      rq[i].push_back({l, d});
   endtask

   task automatic expect_wr(input int i, input logic [7:0] d);
      exp_t e;
      exp_cnt = exp_cnt + 1'b1;
      e.idx = 2'(i);
      e.d   = d;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      exp_q.delete();
      exp_cnt = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Requester model: holds each byte until its ack, then presents the next.
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         if (rq[i].size() > 0) begin
            req[i]         = 1'b1;
            data[8*i +: 8] = rq[i][0][7:0];
            last[i]        = rq[i][0][8];
         end else begin
            req[i]  = 1'b0;
            last[i] = 1'b0;
         end
      end
   end

   // Monitor
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("ack_eq_wrtx_grant", ack, uart_wrtx ? grant : 4'b0);
         chk("busy_eq_grant", busy, |grant);
         chk("grant_onehot", $countones(grant) <= 1, 1);
         if (uart_wrtx) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_write: d=%h ack=%b, required no write", uart_d, ack);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("wr_data", uart_d, e.d);
               chk("wr_ack", ack, 4'b0001 << e.idx);
               chk("wr_count", tx_count, e.cnt);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; req = '0; last = '0; data = '0; uart_thre = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_ack", ack, 0);
      chk("rst_wrtx", uart_wrtx, 0);
      chk("rst_d", uart_d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", tx_count, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Single requester, three-byte packet
      wr_cyc.delete();
      put(1, 8'h41, 0); put(1, 8'h42, 0); put(1, 8'h43, 1);
      expect_wr(1, 8'h41); expect_wr(1, 8'h42); expect_wr(1, 8'h43);
      @(negedge clk);
      chk("t1_grant_before", grant, 4'b0000);
      @(negedge clk);
      chk("t1_grant_latency", grant, 4'b0010);
      @(negedge clk);
      chk("t1_wrtx_latency", uart_wrtx, 1);
      drain();
      @(negedge clk);
      chk("t1_grant_released", grant, 4'b0000);
      chk("t1_count", tx_count, 3);
      chk("t1_nwrites", wr_cyc.size(), 3);
      if (wr_cyc.size() == 3) begin
         chk("t1_spacing_a", wr_cyc[1] - wr_cyc[0], 3);
         chk("t1_spacing_b", wr_cyc[2] - wr_cyc[1], 3);
      end

      // Two contenders, one-byte packets: alternate 0,2,0,2
      do_reset();
      put(0, 8'hA0, 1); put(0, 8'hA1, 1);
      put(2, 8'hC0, 1); put(2, 8'hC1, 1);
      expect_wr(0, 8'hA0); expect_wr(2, 8'hC0);
      expect_wr(0, 8'hA1); expect_wr(2, 8'hC1);
      drain();
      repeat (2) @(negedge clk);

      // THRE low stall longer than the timeout
      uart_thre = 1'b0;
      put(3, 8'h5A, 1);
      repeat (50) @(negedge clk);
      chk("t3_grant_held", grant, 4'b1000);
      chk("t3_no_wrtx", uart_wrtx, 0);
      expect_wr(3, 8'h5A);
      uart_thre = 1'b1;
      @(negedge clk);
      chk("t3_wrtx_after_thre", uart_wrtx, 1);
      drain();
      repeat (2) @(negedge clk);

      // Owner drops req without last; timeout hands over to req2
      put(1, 8'h11, 0);
      put(2, 8'h22, 1);
      expect_wr(1, 8'h11); expect_wr(2, 8'h22);
      n = 0;
      while (!uart_wrtx && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_first_write_seen", uart_wrtx, 1);
      @(negedge clk);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (grant != 4'b0010) break;
         n++;
      end
      chk("t4_hold_cycles", n, 16);
      chk("t4_released", grant, 4'b0000);
      @(negedge clk);
      chk("t4_next_grant", grant, 4'b0100);
      drain();
      repeat (2) @(negedge clk);

      // Reset in the GAP of a 5-byte packet
      for (int k = 0; k < 5; k++) put(3, 8'h31 + 8'(k), k == 4);
      expect_wr(3, 8'h31); expect_wr(3, 8'h32);
      n = 0;
      for (int k = 0; k < 40 && n < 2; k++) begin
         @(negedge clk);
         if (uart_wrtx) n++;
      end
      chk("t5_two_writes", n, 2);
      @(negedge clk);
      chk("t5_grant_in_gap", grant, 4'b1000);
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      exp_q.delete();
      exp_cnt = '0;
      put(0, 8'h70, 1); put(3, 8'h33, 1);
      expect_wr(0, 8'h70); expect_wr(3, 8'h33);
      @(negedge clk);
      chk("t5_rst_grant", grant, 0);
      chk("t5_rst_ack", ack, 0);
      chk("t5_rst_wrtx", uart_wrtx, 0);
      chk("t5_rst_count", tx_count, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_req0_wins", grant, 4'b0001);
      drain();
      repeat (2) @(negedge clk);

      // Counter wrap with a 4-bit counter
      do_reset();
      for (int k = 0; k < 17; k++) begin
         put(1, 8'h80 + 8'(k), 1);
         expect_wr(1, 8'h80 + 8'(k));
      end
      drain();
      @(negedge clk);
      chk("t6_count_wrapped", tx_count, 1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
